alu_op_sequencer: RTL and testbench

- Upstream issue stage for the 4-bit ALU.
- Accepts operation requests (A, B, opcode) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one operation at a time to the ALU's A/B/opcode inputs, waits a fixed ALU latency, then captures the 5-bit result C.
- Presents C, tagged with its opcode, on a valid/ready output port.

---
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 tb/tb_alu_op_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and result signals of the ALU issue sequencer.
// master = environment (requester, ALU, result consumer); slave = sequencer.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_a;
  logic [DATA_W-1:0]       in_b;
  logic [1:0]              in_op;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic [1:0]              alu_op;
  logic [DATA_W:0]         alu_c;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W:0]         out_c;
  logic [1:0]              out_op;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output in_valid, in_a, in_b, in_op, alu_c, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_c, out_op, fifo_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_c, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_c, out_op, fifo_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for the ALU: buffers requests in a FIFO, issues one at a time,
// waits the fixed ALU latency and presents the tagged result on a valid/ready port.
module alu_op_sequencer #(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(ALU_LAT + 1) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
  } req_t;

  req_t              mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        state;
  logic [LW-1:0]     cnt;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        op_q;
  logic [DATA_W:0]   c_q;
  logic [1:0]        cop_q;
  logic              vld_q;

  logic full, empty, push, issue;
  req_t head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // No pass-through: a pop in the same cycle never frees room for a push.
  assign bus.in_ready = rst && !full;
  assign push  = bus.in_valid && bus.in_ready;
  assign issue = !empty && ((state == IDLE) || (state == HOLD && bus.out_ready));
  assign head  = mem[rd_ptr];

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.out_c      = c_q;
  assign bus.out_op     = cop_q;
  assign bus.out_valid  = vld_q;
  assign bus.fifo_count = count;

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      c_q   <= '0;
      cop_q <= '0;
      vld_q <= 1'b0;
    end else begin
      // issue is only ever true in IDLE or in HOLD on a handshake
      if (issue) begin
        a_q   <= head.a;
        b_q   <= head.b;
        op_q  <= head.op;
        cnt   <= LW'(ALU_LAT);
        state <= WAIT;
      end
      case (state)
        WAIT: begin
          if (cnt == '0) begin
            c_q   <= bus.alu_c;
            cop_q <= op_q;
            vld_q <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt - LW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            if (!issue) state <= IDLE;
          end
        end
        IDLE:    ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of single-op vectors plus
// hand-written backpressure, back-to-back, reset and zero-latency sequences.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(4), .DEPTH(4)) bus1 ();
  alu_op_sequencer_if #(.DATA_W(4), .DEPTH(4)) bus0 ();

  alu_op_sequencer #(.DATA_W(4), .DEPTH(4), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  alu_op_sequencer #(.DATA_W(4), .DEPTH(4), .ALU_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));

  // ALU stubs: C = A + B for every opcode, one registered stage / combinational
  always_ff @(posedge clk) bus1.alu_c <= {1'b0, bus1.alu_a} + 5'(bus1.alu_b);
  assign bus0.alu_c = {1'b0, bus0.alu_a} + 5'(bus0.alu_b);

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [4:0] c;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bus1.in_valid = v;
    bus1.in_a     = a;
    bus1.in_b     = b;
    bus1.in_op    = op;
  endtask

  initial begin
    int got [$];
    int t;
    int seen;
    int exp_bp [5];

    vecs[0] = '{a: 4'd2,  b: 4'd1,  op: 2'b00, c: 5'd3};
    vecs[1] = '{a: 4'd15, b: 4'd10, op: 2'b11, c: 5'd25};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  op: 2'b01, c: 5'd0};
    vecs[3] = '{a: 4'd7,  b: 4'd9,  op: 2'b10, c: 5'd16};
    vecs[4] = '{a: 4'd15, b: 4'd15, op: 2'b00, c: 5'd30};
    exp_bp = '{7, 15, 2, 4, 10};

    drive1(1'b0, 4'd0, 4'd0, 2'b00);
    bus1.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_op = '0;
    bus0.out_ready = 1'b0;

    // reset state
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",   32'(bus1.in_ready),   0);
    chk("rst_fifo_count", 32'(bus1.fifo_count), 0);
    chk("rst_out_valid",  32'(bus1.out_valid),  0);
    chk("rst_alu_a",      32'(bus1.alu_a),      0);
    chk("rst_out_c",      32'(bus1.out_c),      0);
    step();
    rst = 1'b1;
    #1 chk("rel_in_ready", 32'(bus1.in_ready), 1);

    // single-op vectors, out_ready high
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive1(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      step();
      chk($sformatf("v%0d_count_push", i), 32'(bus1.fifo_count), 1);
      bus1.in_valid = 1'b0;
      step();
      chk($sformatf("v%0d_alu_a", i),  32'(bus1.alu_a),  32'(vecs[i].a));
      chk($sformatf("v%0d_alu_b", i),  32'(bus1.alu_b),  32'(vecs[i].b));
      chk($sformatf("v%0d_alu_op", i), 32'(bus1.alu_op), 32'(vecs[i].op));
      chk($sformatf("v%0d_count_issue", i), 32'(bus1.fifo_count), 0);
      chk($sformatf("v%0d_vld_e1", i), 32'(bus1.out_valid), 0);
      step();
      chk($sformatf("v%0d_vld_e2", i), 32'(bus1.out_valid), 0);
      step();
      chk($sformatf("v%0d_vld_e3", i), 32'(bus1.out_valid), 1);
      chk($sformatf("v%0d_out_c", i),  32'(bus1.out_c),  32'(vecs[i].c));
      chk($sformatf("v%0d_out_op", i), 32'(bus1.out_op), 32'(vecs[i].op));
      step();
      chk($sformatf("v%0d_vld_e4", i), 32'(bus1.out_valid), 0);
    end

    // backpressure: fill, stall a sixth request, then drain in order
    bus1.out_ready = 1'b0;
    drive1(1'b1, 4'd4, 4'd3, 2'b00); step();
    drive1(1'b1, 4'd9, 4'd6, 2'b00); step();
    chk("bp_count_pushpop", 32'(bus1.fifo_count), 1);
    drive1(1'b1, 4'd1, 4'd1, 2'b00); step();
    drive1(1'b1, 4'd2, 4'd2, 2'b00); step();
    drive1(1'b1, 4'd5, 4'd5, 2'b00); step();
    chk("bp_count_full", 32'(bus1.fifo_count), 4);
    chk("bp_in_ready",   32'(bus1.in_ready),   0);
    chk("bp_out_valid",  32'(bus1.out_valid),  1);
    chk("bp_out_c_held", 32'(bus1.out_c),      7);
    drive1(1'b1, 4'd6, 4'd6, 2'b00);
    repeat (3) step();
    chk("bp_count_stall", 32'(bus1.fifo_count), 4);
    chk("bp_out_c_stall", 32'(bus1.out_c),      7);
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus1.out_valid) got.push_back(int'(bus1.out_c));
      step();
    end
    chk("bp_num_results", 32'(got.size()), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_result%0d", i),
          (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_bp[i]));

    // back-to-back HOLD -> WAIT with no idle bubble
    drive1(1'b1, 4'd3, 4'd4, 2'b01); step();
    drive1(1'b1, 4'd8, 4'd8, 2'b10); step();
    bus1.in_valid = 1'b0;
    t = 0;
    while (!bus1.out_valid && t < 10) begin step(); t++; end
    chk("b2b_first_c",  32'(bus1.out_c),  7);
    chk("b2b_first_op", 32'(bus1.out_op), 1);
    t = 0;
    step(); t++;
    while (!bus1.out_valid && t < 10) begin step(); t++; end
    chk("b2b_gap",       32'(t),             3);
    chk("b2b_second_c",  32'(bus1.out_c),   16);
    chk("b2b_second_op", 32'(bus1.out_op),   2);
    chk("b2b_alu_a",     32'(bus1.alu_a),    8);
    step();
    chk("b2b_drained", 32'(bus1.out_valid), 0);

    // asynchronous reset while waiting with two entries queued
    bus1.out_ready = 1'b0;
    drive1(1'b1, 4'd1, 4'd1, 2'b00); step();
    drive1(1'b1, 4'd2, 4'd2, 2'b00); step();
    drive1(1'b1, 4'd3, 4'd3, 2'b00); step();
    bus1.in_valid = 1'b0;
    chk("mr_count_pre", 32'(bus1.fifo_count), 2);
    #2 rst = 1'b0;
    #1;
    chk("mr_out_valid", 32'(bus1.out_valid),  0);
    chk("mr_count",     32'(bus1.fifo_count), 0);
    chk("mr_alu_a",     32'(bus1.alu_a),      0);
    chk("mr_in_ready",  32'(bus1.in_ready),   0);
    @(negedge clk);
    step();
    rst = 1'b1;
    bus1.out_ready = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus1.out_valid) seen++;
      step();
    end
    chk("mr_no_stale", 32'(seen), 0);
    drive1(1'b1, 4'd1, 4'd2, 2'b00); step();
    bus1.in_valid = 1'b0;
    step(); step(); step();
    chk("mr_new_valid", 32'(bus1.out_valid), 1);
    chk("mr_new_c",     32'(bus1.out_c),     3);
    step();

    // zero-latency build: result two edges after the push
    bus0.out_ready = 1'b1;
    bus0.in_valid = 1'b1; bus0.in_a = 4'd6; bus0.in_b = 4'd6; bus0.in_op = 2'b11;
    step();
    bus0.in_valid = 1'b0;
    step();
    chk("l0_vld_e1", 32'(bus0.out_valid), 0);
    chk("l0_alu_a",  32'(bus0.alu_a),     6);
    step();
    chk("l0_vld_e2", 32'(bus0.out_valid), 1);
    chk("l0_out_c",  32'(bus0.out_c),    12);
    chk("l0_out_op", 32'(bus0.out_op),    3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
